// File: rtl/i_cache_if.sv
// Fetch-side and refill-side signal bundle for the instruction cache.
// The slave modport is the cache's view; master is the CPU/memory side.
interface i_cache_if #(
   parameter int LINE_WIDTH = 128,
   parameter int WORD_WIDTH = 32,
   parameter int ADDR_WIDTH = 32
) ();
   logic [ADDR_WIDTH-1:0] cpu_addr_i;
   logic                  cpu_req_i;
   logic [WORD_WIDTH-1:0] cpu_inst_o;
   logic                  cpu_valid_o;
   logic                  mem_req_o;
   logic [ADDR_WIDTH-1:0] mem_addr_o;
   logic                  mem_valid_i;
   logic [LINE_WIDTH-1:0] mem_inst_i;

   modport slave (
      input  cpu_addr_i,
      input  cpu_req_i,
      output cpu_inst_o,
      output cpu_valid_o,
      output mem_req_o,
      output mem_addr_o,
      input  mem_valid_i,
      input  mem_inst_i
   );

   modport master (
      output cpu_addr_i,
      output cpu_req_i,
      input  cpu_inst_o,
      input  cpu_valid_o,
      input  mem_req_o,
      input  mem_addr_o,
      output mem_valid_i,
      output mem_inst_i
   );
endinterface

// File: rtl/i_cache.sv
// Set-associative read-only instruction cache, one request in flight.
// Misses refill a whole line and forward the requested word.
module i_cache #(
   parameter int LINE_WIDTH = 128,
   parameter int WORD_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int NUM_WAYS   = 4,
   parameter int NUM_SETS   = 16
) (
   input logic clk,
   input logic rst,
   i_cache_if.slave bus
);
   localparam int OFF    = $clog2(LINE_WIDTH / 8);
   localparam int IDX    = $clog2(NUM_SETS);
   localparam int TAG_W  = ADDR_WIDTH - OFF - IDX;
   localparam int WSEL_W = OFF - 2;
   localparam int WORDS  = LINE_WIDTH / WORD_WIDTH;
   localparam int WAY_W  = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;

   typedef enum logic [1:0] {
      IDLE,
      LOOKUP,
      MISS
   } state_t;

   state_t state_q, state_d;

   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [WORD_WIDTH-1:0] inst_q, inst_d;
   logic                  valid_q, valid_d;
   logic                  mreq_q, mreq_d;
   logic [ADDR_WIDTH-1:0] maddr_q, maddr_d;
   logic                  fill;

   logic [NUM_WAYS-1:0]   vbit_q [NUM_SETS];
   logic [WAY_W-1:0]      rr_q   [NUM_SETS];
   logic [TAG_W-1:0]      tag_q  [NUM_SETS][NUM_WAYS];
   logic [LINE_WIDTH-1:0] data_q [NUM_SETS][NUM_WAYS];

   logic [WSEL_W-1:0] wsel;
   logic [IDX-1:0]    idx;
   logic [TAG_W-1:0]  tag;

   logic              hit;
   logic [WAY_W-1:0]  hit_way;
   logic [WAY_W-1:0]  vic;
   logic              vic_free;
   logic [WORD_WIDTH-1:0] hit_word;
   logic [WORD_WIDTH-1:0] fill_word;

   // byte offset within a word never affects the fetch
   logic unused_ok;
   assign unused_ok = ^addr_q[1:0];

   assign wsel = addr_q[OFF-1:2];
   assign idx  = addr_q[OFF+IDX-1:OFF];
   assign tag  = addr_q[ADDR_WIDTH-1:OFF+IDX];

   function automatic logic [WORD_WIDTH-1:0] pick(
      input logic [LINE_WIDTH-1:0] line,
      input logic [WSEL_W-1:0]     sel
   );
      pick = '0;
      for (int k = 0; k < WORDS; k++) begin
         if (sel == WSEL_W'(k)) begin
            pick = line[k*WORD_WIDTH +: WORD_WIDTH];
         end
      end
   endfunction

   always_comb begin
      hit     = 1'b0;
      hit_way = '0;
      for (int w = 0; w < NUM_WAYS; w++) begin
         if (!hit && vbit_q[idx][w] && tag_q[idx][w] == tag) begin
            hit     = 1'b1;
            hit_way = WAY_W'(w);
         end
      end
   end

   // lowest invalid way wins; otherwise the set's round-robin pointer
   always_comb begin
      vic      = rr_q[idx];
      vic_free = 1'b0;
      for (int w = 0; w < NUM_WAYS; w++) begin
         if (!vic_free && !vbit_q[idx][w]) begin
            vic_free = 1'b1;
            vic      = WAY_W'(w);
         end
      end
   end

   assign hit_word  = pick(data_q[idx][hit_way], wsel);
   assign fill_word = pick(bus.mem_inst_i, wsel);

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      inst_d  = inst_q;
      valid_d = 1'b0;
      mreq_d  = mreq_q;
      maddr_d = maddr_q;
      fill    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (bus.cpu_req_i) begin
               addr_d  = bus.cpu_addr_i;
               state_d = LOOKUP;
            end
         end
         LOOKUP: begin
            if (hit) begin
               inst_d  = hit_word;
               valid_d = 1'b1;
               state_d = IDLE;
            end else begin
               mreq_d  = 1'b1;
               maddr_d = {addr_q[ADDR_WIDTH-1:OFF], {OFF{1'b0}}};
               state_d = MISS;
            end
         end
         MISS: begin
            if (bus.mem_valid_i) begin
               fill    = 1'b1;
               inst_d  = fill_word;
               valid_d = 1'b1;
               mreq_d  = 1'b0;
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         addr_q  <= '0;
         inst_q  <= '0;
         valid_q <= 1'b0;
         mreq_q  <= 1'b0;
         maddr_q <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         inst_q  <= inst_d;
         valid_q <= valid_d;
         mreq_q  <= mreq_d;
         maddr_q <= maddr_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int s = 0; s < NUM_SETS; s++) begin
            vbit_q[s] <= '0;
            rr_q[s]   <= '0;
         end
      end else if (fill) begin
         vbit_q[idx][vic] <= 1'b1;
         if (!vic_free) begin
            rr_q[idx] <= rr_q[idx] + WAY_W'(1);
         end
      end
   end

   // tag and data arrays carry no reset; valid bits gate them
   always_ff @(posedge clk) begin
      if (fill) begin
         tag_q[idx][vic]  <= tag;
         data_q[idx][vic] <= bus.mem_inst_i;
      end
   end

   assign bus.cpu_inst_o  = inst_q;
   assign bus.cpu_valid_o = valid_q;
   assign bus.mem_req_o   = mreq_q;
   assign bus.mem_addr_o  = maddr_q;
endmodule

// File: tb/tb_i_cache.sv
// Scoreboard bench for i_cache: expected words queued at request time,
// popped whenever the cache pulses cpu_valid_o.
module tb_i_cache;
   logic clk = 1'b0;
   logic rst = 1'b1;

   i_cache_if #(
      .LINE_WIDTH(128),
      .WORD_WIDTH(32),
      .ADDR_WIDTH(32)
   ) bus ();

   i_cache #(
      .LINE_WIDTH(128),
      .WORD_WIDTH(32),
      .ADDR_WIDTH(32),
      .NUM_WAYS(4),
      .NUM_SETS(16)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;
   logic [31:0] sb [$];

   task automatic check(
      input string       tag,
      input logic [31:0] obs,
      input logic [31:0] exp
   );
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [127:0] line_of(input logic [31:0] a);
      logic [31:0] b;
      b = {a[31:4], 4'h0};
      return {b + 32'hC, b + 32'h8, b + 32'h4, b};
   endfunction

   function automatic logic [31:0] word_of(input logic [31:0] a);
      return {a[31:2], 2'b00};
   endfunction

   always @(negedge clk) begin
      if (bus.cpu_valid_o === 1'b1) begin
         if (sb.size() == 0) begin
            check("spurious_valid", 32'd1, 32'd0);
         end else begin
            check("sb_inst", bus.cpu_inst_o, sb.pop_front());
         end
      end
   end

   task automatic req(input logic [31:0] a, input bit now);
      if (!now) begin
         @(posedge clk);
         #1;
      end
      bus.cpu_addr_i = a;
      bus.cpu_req_i  = 1'b1;
      @(posedge clk);
      #1;
      bus.cpu_req_i  = 1'b0;
   endtask

   task automatic fetch_hit(input logic [31:0] a, input bit now);
      req(a, now);
      sb.push_back(word_of(a));
      @(posedge clk);
      #1;
      check("hit_valid", 32'(bus.cpu_valid_o), 32'd1);
      check("hit_noreq", 32'(bus.mem_req_o), 32'd0);
   endtask

   task automatic mem_reply(input logic [127:0] line);
      bus.mem_inst_i  = line;
      bus.mem_valid_i = 1'b1;
      @(posedge clk);
      #1;
      bus.mem_valid_i = 1'b0;
   endtask

   task automatic fetch_miss(input logic [31:0] a, input int lat);
      logic [31:0] la;
      la = {a[31:4], 4'h0};
      req(a, 1'b0);
      @(posedge clk);
      #1;
      check("miss_req", 32'(bus.mem_req_o), 32'd1);
      check("miss_addr", bus.mem_addr_o, la);
      check("miss_novalid", 32'(bus.cpu_valid_o), 32'd0);
      for (int i = 0; i < lat; i++) begin
         @(posedge clk);
         #1;
         check("miss_hold_req", 32'(bus.mem_req_o), 32'd1);
         check("miss_hold_addr", bus.mem_addr_o, la);
      end
      sb.push_back(word_of(a));
      mem_reply(line_of(a));
      check("fill_req_low", 32'(bus.mem_req_o), 32'd0);
      check("fill_valid", 32'(bus.cpu_valid_o), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      bus.cpu_addr_i  = '0;
      bus.cpu_req_i   = 1'b0;
      bus.mem_valid_i = 1'b0;
      bus.mem_inst_i  = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_valid", 32'(bus.cpu_valid_o), 32'd0);
      check("rst_req", 32'(bus.mem_req_o), 32'd0);
      check("rst_maddr", bus.mem_addr_o, 32'd0);
      check("rst_inst", bus.cpu_inst_o, 32'd0);
      rst = 1'b0;

      fetch_miss(32'h40, 2);
      fetch_hit(32'h4C, 1'b0);
      fetch_hit(32'h43, 1'b0);

      fetch_miss(32'h240, 0);
      fetch_hit(32'h40, 1'b0);

      fetch_miss(32'h140, 1);
      fetch_miss(32'h340, 3);
      fetch_miss(32'h440, 1);
      fetch_miss(32'h40, 0);
      fetch_hit(32'h148, 1'b0);
      fetch_hit(32'h444, 1'b0);
      fetch_hit(32'h34C, 1'b1);
      fetch_miss(32'h240, 2);
      fetch_hit(32'h44, 1'b0);
      fetch_miss(32'h148, 0);

      req(32'h80, 1'b0);
      @(posedge clk);
      #1;
      check("ign_req_up", 32'(bus.mem_req_o), 32'd1);
      bus.cpu_addr_i = 32'h44;
      bus.cpu_req_i  = 1'b1;
      @(posedge clk);
      #1;
      bus.cpu_req_i  = 1'b0;
      @(posedge clk);
      #1;
      check("ign_req_novalid", 32'(bus.cpu_valid_o), 32'd0);
      check("ign_req_addr", bus.mem_addr_o, 32'h80);
      sb.push_back(32'h80);
      mem_reply(line_of(32'h80));
      check("ign_fill_valid", 32'(bus.cpu_valid_o), 32'd1);
      @(posedge clk);
      #1;
      check("ign_no_second", 32'(bus.cpu_valid_o), 32'd0);
      @(posedge clk);
      #1;
      check("ign_no_third", 32'(bus.cpu_valid_o), 32'd0);

      mem_reply({4{32'hDEAD_BEEF}});
      check("idle_mv_valid", 32'(bus.cpu_valid_o), 32'd0);
      check("idle_mv_req", 32'(bus.mem_req_o), 32'd0);
      @(posedge clk);
      #1;
      check("idle_mv_valid2", 32'(bus.cpu_valid_o), 32'd0);
      fetch_hit(32'h88, 1'b0);

      req(32'h500, 1'b0);
      @(posedge clk);
      #1;
      check("rst_miss_up", 32'(bus.mem_req_o), 32'd1);
      #2;
      rst = 1'b1;
      #1;
      check("rst_async_req", 32'(bus.mem_req_o), 32'd0);
      check("rst_async_maddr", bus.mem_addr_o, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      fetch_miss(32'h40, 1);
      fetch_hit(32'h40, 1'b0);

      repeat (3) @(posedge clk);
      #1;
      check("sb_empty", 32'(sb.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/i_cache.md
# i_cache

Set-associative, read-only instruction cache sitting between the CPU fetch stage and the instruction memory/next-level port. It accepts single-cycle fetch requests, returns one word per request, and on a miss fetches a full line from memory, allocates it into the set, and forwards the requested word. No writes, no coherency actions, and one outstanding request at a time.

## Interface
- LINE_WIDTH, 128: line size in bits; the memory returns one full line per refill.
- WORD_WIDTH, 32: instruction word size in bits.
- ADDR_WIDTH, 32: byte address width.
- NUM_WAYS, 4: associativity; power of two.
- NUM_SETS, 16: number of sets; power of two.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- cpu_addr_i  in  ADDR_WIDTH  fetch byte address; sampled with cpu_req_i.
- cpu_req_i  in  1  one-cycle fetch request pulse.
- cpu_inst_o  out  WORD_WIDTH  returned instruction word.
- cpu_valid_o  out  1  one-cycle pulse; cpu_inst_o is valid.
- mem_req_o  out  1  refill request; held high until mem_valid_i.
- mem_addr_o  out  ADDR_WIDTH  line-aligned refill address.
- mem_valid_i  in  1  one-cycle pulse; mem_inst_i carries the line.
- mem_inst_i  in  LINE_WIDTH  refill line; word k occupies bits [k*WORD_WIDTH +: WORD_WIDTH].

## Operation
- Address split (defaults): OFF = log2(LINE_WIDTH/8) = 4 bits; IDX = log2(NUM_SETS) = 4 bits; word select = addr[OFF-1:2]; index = addr[OFF+IDX-1:OFF]; tag = remaining upper bits (24 bits). Byte bits addr[1:0] are ignored.
- Storage per set and way: valid bit, tag, and a LINE_WIDTH data line. Valid bits are reset; tag and data arrays are not.
- FSM states:
  - IDLE: on cpu_req_i, latch the address and go to LOOKUP. Without a request, stay in IDLE.
  - LOOKUP: compare the tag across all ways of the indexed set.
    - Hit: register cpu_inst_o = selected word, pulse cpu_valid_o, go to IDLE.
    - Miss: register mem_req_o=1 and mem_addr_o = latched address with the low OFF bits zeroed, go to MISS.
  - MISS: hold mem_req_o and mem_addr_o. On mem_valid_i:
    - Write mem_inst_i, the tag and valid=1 into the victim way.
    - Set cpu_inst_o to the requested word from mem_inst_i and pulse cpu_valid_o.
    - Drop mem_req_o and go to IDLE.
- Victim selection: the lowest-indexed invalid way. If every way is valid, use a per-set round-robin pointer (reset to 0), which advances by one (modulo NUM_WAYS) on every eviction.
- cpu_req_i outside IDLE is ignored; the request is dropped and is not queued. mem_valid_i outside MISS is ignored.
- cpu_inst_o holds its last value between pulses.

## Timing
- Reset (asynchronous, immediate): state=IDLE, all valid bits=0, round-robin pointers=0, cpu_valid_o=0, cpu_inst_o=0, mem_req_o=0, mem_addr_o=0. Reset during MISS abandons the refill; mem_req_o drops immediately.
- Hit latency: request sampled at edge N, cpu_valid_o high during the cycle after edge N+1 (2 edges).
- Miss: request sampled at edge N; mem_req_o high after edge N+1. With mem_valid_i sampled at edge M, cpu_valid_o is high for the cycle after M and mem_req_o is low from M.
- The FSM is back in IDLE during the cycle cpu_valid_o is high. A request presented in that cycle is accepted, allowing back-to-back requests.
- The memory may take any number of cycles to answer; mem_req_o and mem_addr_o stay stable throughout.

## Test plan
- After reset, request 0x0000_0040: expect a miss, mem_req_o=1 and mem_addr_o=0x40. Return line {0x4C,0x48,0x44,0x40}; expect a cpu_valid_o pulse with cpu_inst_o=0x0000_0040 and mem_req_o low.
- Request 0x0000_004C: expect a hit with no mem_req_o and cpu_inst_o=0x0000_004C two edges after the request. Also request 0x43: expect 0x40.
- Request 0x0000_0240 (same set 4, new tag): expect a miss with mem_addr_o=0x240 and returned word 0x240. Then request 0x40: expect a hit, since the line sits in a different way.
- Fill set 4 with tags 0x40, 0x140, 0x240, 0x340, then request 0x440: expect it to evict way 0 (0x40). A subsequent 0x40 request misses while 0x140 still hits.
- Assert cpu_req_i while in MISS: expect it to be ignored. Pulse mem_valid_i in IDLE: expect no state change.
- Assert rst while mem_req_o is high: expect mem_req_o=0 immediately. A subsequent request to 0x40 misses, since valid bits are cleared.
